// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed driver for an N-digit common-anode seven-segment display.
//   A divider walks the digit slots. Each slot starts with a short dark
//   interval, which stops the previous digit ghosting into the next one.
//   Display data is double buffered so that a frame is never torn:
//   upd captures the inputs into staging, and staging moves to the shadow
//   (displayed) copy only at a frame boundary.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   digits      4*NUM_DIGITS nibbles, digit k = digits[4k+3:4k], digit 0 rightmost
//   dp          per-digit decimal point request, 1 = lit
//   blank_mask  per-digit blank, 1 = digit fully dark
//   upd         single-cycle strobe, captures digits/dp/blank_mask
//   segs        segment drive {a,b,c,d,e,f,g}, active-low
//   dp_n        decimal point drive, active-low
//   an          anode select, active-low, one-hot-low when a digit is lit
//   frame_done  one-cycle pulse on the last cycle of each frame
//
// Build option
//   SEG_SCAN_HEX_DECODE_EN : when defined, nibbles 10..15 show A,b,C,d,E,F.
//                            When undefined, those nibbles leave the segments dark.
//
// Slot timing
//   state           | meaning
//   div < BLANK     | slot dark, all anodes off
//   div >= BLANK    | digit idx lit from the shadow copy, unless it is masked

module seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    upd,
    output logic [6:0]              segs,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [DW-1:0]           div, div_next;
    logic [IW-1:0]           idx, idx_next;
    logic                    tc, boundary;

    logic [4*NUM_DIGITS-1:0] stg_digits, sh_digits, sh_digits_next;
    logic [NUM_DIGITS-1:0]   stg_dp, sh_dp, sh_dp_next;
    logic [NUM_DIGITS-1:0]   stg_bm, sh_bm, sh_bm_next;
    logic                    pending, pending_next;

    logic                    in_blank, active;
    logic [3:0]              nibble;
    logic [6:0]              segs_next;
    logic                    dp_n_next;
    logic [NUM_DIGITS-1:0]   an_next;
    logic                    frame_done_next;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
`ifdef SEG_SCAN_HEX_DECODE_EN
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
`else
            default: s = 7'b1111111;
`endif
        endcase
        return s;
    endfunction

    assign tc       = (div == DW'(CLK_DIV - 1));
    assign boundary = tc && (idx == IW'(NUM_DIGITS - 1));

    always_comb begin
        div_next = tc ? '0 : div + DW'(1);
        idx_next = idx;
        if (tc)
            idx_next = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
    end

    // An upd on the boundary edge bypasses staging. Otherwise it would be
    // parked in staging for a whole frame for no benefit.
    always_comb begin
        sh_digits_next = sh_digits;
        sh_dp_next     = sh_dp;
        sh_bm_next     = sh_bm;
        pending_next   = pending;
        if (boundary) begin
            pending_next = 1'b0;
            if (upd) begin
                sh_digits_next = digits;
                sh_dp_next     = dp;
                sh_bm_next     = blank_mask;
            end else if (pending) begin
                sh_digits_next = stg_digits;
                sh_dp_next     = stg_dp;
                sh_bm_next     = stg_bm;
            end
        end else if (upd) begin
            pending_next = 1'b1;
        end
    end

    // Outputs come from next-state values, so they register on the same edge
    // as the counters and there is no one-cycle skew.
    always_comb begin
        in_blank        = (BLANK_CYCLES > 0) && (div_next < DW'(BLANK_CYCLES));
        active          = !in_blank && !sh_bm_next[idx_next];
        nibble          = sh_digits_next[{idx_next, 2'b00} +: 4];
        an_next         = active ? ~(NUM_DIGITS'(1) << idx_next) : '1;
        segs_next       = active ? decode(nibble) : 7'b1111111;
        dp_n_next       = active ? ~sh_dp_next[idx_next] : 1'b1;
        frame_done_next = (idx_next == IW'(NUM_DIGITS - 1)) &&
                          (div_next == DW'(CLK_DIV - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div        <= '0;
            idx        <= '0;
            stg_digits <= '0;
            stg_dp     <= '0;
            stg_bm     <= '0;
            sh_digits  <= '0;
            sh_dp      <= '0;
            sh_bm      <= '0;
            pending    <= 1'b0;
            an         <= '1;
            segs       <= 7'b1111111;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            div        <= div_next;
            idx        <= idx_next;
            if (upd) begin
                stg_digits <= digits;
                stg_dp     <= dp;
                stg_bm     <= blank_mask;
            end
            sh_digits  <= sh_digits_next;
            sh_dp      <= sh_dp_next;
            sh_bm      <= sh_bm_next;
            pending    <= pending_next;
            an         <= an_next;
            segs       <= segs_next;
            dp_n       <= dp_n_next;
            frame_done <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2.
// cyc counts the cycles since reset was released, so div = cyc%8 and slot = (cyc/8)%4.
// e_dig/e_dp/e_bm hold the frame that should be on display. They are set by hand
// at the points where each update is due to appear.

module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank_mask;
    logic        upd;
    logic [6:0]  segs;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_done;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [15:0] e_dig;
    logic [3:0]  e_dp;
    logic [3:0]  e_bm;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .NUM_DIGITS  (4),
        .CLK_DIV     (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .digits    (digits),
        .dp        (dp),
        .blank_mask(blank_mask),
        .upd       (upd),
        .segs      (segs),
        .dp_n      (dp_n),
        .an        (an),
        .frame_done(frame_done)
    );

    function automatic logic [6:0] exp_dec(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
`ifdef SEG_SCAN_HEX_DECODE_EN
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
`else
            default: return 7'b1111111;
`endif
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_off(input string tag);
        n_cmp++;
        assert (an === 4'b1111) else begin
            n_err++; $error("FAIL %s an got %b want 1111", tag, an);
        end
        n_cmp++;
        assert (segs === 7'b1111111) else begin
            n_err++; $error("FAIL %s segs got %b want 1111111", tag, segs);
        end
        n_cmp++;
        assert (dp_n === 1'b1) else begin
            n_err++; $error("FAIL %s dp_n got %b want 1", tag, dp_n);
        end
        n_cmp++;
        assert (frame_done === 1'b0) else begin
            n_err++; $error("FAIL %s frame_done got %b want 0", tag, frame_done);
        end
    endtask

    task automatic check_now(input string tag);
        int         d;
        int         s;
        logic       act;
        logic [3:0] w_an;
        logic [6:0] w_segs;
        logic       w_dp;
        logic       w_fd;
        d      = cyc % 8;
        s      = (cyc / 8) % 4;
        act    = (d >= 2) && !e_bm[s];
        w_an   = act ? ~(4'b0001 << s) : 4'b1111;
        w_segs = act ? exp_dec(e_dig[s*4 +: 4]) : 7'b1111111;
        w_dp   = act ? ~e_dp[s] : 1'b1;
        w_fd   = ((cyc % 32) == 31);
        n_cmp++;
        assert (an === w_an) else begin
            n_err++; $error("FAIL %s cyc=%0d an got %b want %b", tag, cyc, an, w_an);
        end
        n_cmp++;
        assert (segs === w_segs) else begin
            n_err++; $error("FAIL %s cyc=%0d segs got %b want %b", tag, cyc, segs, w_segs);
        end
        n_cmp++;
        assert (dp_n === w_dp) else begin
            n_err++; $error("FAIL %s cyc=%0d dp_n got %b want %b", tag, cyc, dp_n, w_dp);
        end
        n_cmp++;
        assert (frame_done === w_fd) else begin
            n_err++; $error("FAIL %s cyc=%0d frame_done got %b want %b", tag, cyc, frame_done, w_fd);
        end
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            check_now(tag);
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; digits = '0; dp = '0; blank_mask = '0; upd = 1'b0;
        e_dig = '0; e_dp = '0; e_bm = '0;

        #12;
        check_off("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;

        // After release, frame 0 shows zeros. An update mid-frame must not show yet.
        run(10, "zeros");
        check_now("pre_upd");
        digits = 16'h1234; upd = 1'b1;
        tick();
        upd = 1'b0;
        run(21, "old_frame");
        e_dig = 16'h1234;
        run(31, "frame_1234");

        // The upd below is sampled on the boundary edge, so it appears immediately.
        check_now("boundary");
        digits = 16'h9999; upd = 1'b1;
        tick();
        upd = 1'b0;
        e_dig = 16'h9999;
        run(6, "frame_9999");

        // Two updates in one frame: the last one wins.
        check_now("upd_a");
        digits = 16'h1111; upd = 1'b1;
        tick();
        upd = 1'b0;
        run(9, "frame_9999b");
        check_now("upd_b");
        digits = 16'h2222; upd = 1'b1;
        tick();
        upd = 1'b0;
        run(15, "frame_9999c");
        e_dig = 16'h2222;
        run(4, "frame_2222");

        // Test the decimal point, the blank mask and a hex nibble in one frame.
        check_now("upd_c");
        digits = 16'h56A8; dp = 4'b0001; blank_mask = 4'b0100; upd = 1'b1;
        tick();
        upd = 1'b0;
        run(27, "frame_2222b");
        e_dig = 16'h56A8; e_dp = 4'b0001; e_bm = 4'b0100;
        run(19, "frame_mix");

        // Apply reset asynchronously mid slot 2. The outputs must go dark with no clock edge.
        check_now("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check_off("async_reset");
        @(posedge clk);
        #1;
        check_off("reset_hold");
        rst_n = 1'b1;
        cyc   = 0;
        e_dig = '0; e_dp = '0; e_bm = '0;
        run(16, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
